// File: rtl/lut_cfg_loader_if.sv
// Serial configuration handshake for the LUT loader.
// Master drives start/data/valid; slave returns ready/done/err.
interface lut_cfg_loader_if;
  logic cfg_start;
  logic cfg_din;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_done;
  logic cfg_err;

  modport master (
    output cfg_start,
    output cfg_din,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_start,
    input  cfg_din,
    input  cfg_valid,
    output cfg_ready,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/lut_cfg_loader.sv
// 3-input LUT whose truth table is reloaded over a serial bit stream.
// Define LUT_CFG_PARITY_EN to require a trailing even-parity bit.
module lut_cfg_loader #(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  lut_cfg_loader_if.slave  cfg,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             s,
  output logic [7:0]       cfg_word
);

`ifdef LUT_CFG_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PAR    = 2'd2,
    COMMIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd3
  } state_t;
`endif

  state_t      state;
  state_t      nxt;
  logic [2:0]  cnt;
  logic [7:0]  shadow;
  logic [7:0]  table_q;
  logic        done_q;
  logic        ready;
  logic        clr;
  logic        shift_en;
  logic        load;
`ifdef LUT_CFG_PARITY_EN
  logic        err_set;
  logic        err_q;
`endif

  // Next state and per-cycle controls; start wins over a data bit.
  always_comb begin
    nxt      = state;
    ready    = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
`ifdef LUT_CFG_PARITY_EN
    err_set  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (cfg.cfg_start) begin
          nxt = SHIFT;
          clr = 1'b1;
        end
      end
      SHIFT: begin
        ready = 1'b1;
        if (cfg.cfg_start) begin
          clr = 1'b1;
        end else if (cfg.cfg_valid) begin
          shift_en = 1'b1;
          if (cnt == 3'd7) begin
`ifdef LUT_CFG_PARITY_EN
            nxt = PAR;
`else
            nxt = COMMIT;
`endif
          end
        end
      end
`ifdef LUT_CFG_PARITY_EN
      PAR: begin
        ready = 1'b1;
        if (cfg.cfg_start) begin
          nxt = SHIFT;
          clr = 1'b1;
        end else if (cfg.cfg_valid) begin
          if (^{shadow, cfg.cfg_din}) begin
            err_set = 1'b1;
            nxt     = IDLE;
          end else begin
            nxt = COMMIT;
          end
        end
      end
`endif
      COMMIT: begin
        load = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Bit counter and shadow register, filled LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      shadow <= 8'h00;
    end else if (clr) begin
      cnt    <= 3'd0;
      shadow <= 8'h00;
    end else if (shift_en) begin
      cnt         <= cnt + 3'd1;
      shadow[cnt] <= cfg.cfg_din;
    end
  end

  // Active table only changes on a commit, never mid-load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    table_q <= INIT;
    else if (load) table_q <= shadow;
  end

  // Registered status pulses, aligned with the table update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= load;
`ifdef LUT_CFG_PARITY_EN
      err_q  <= err_set;
`endif
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_done  = done_q;
`ifdef LUT_CFG_PARITY_EN
  assign cfg.cfg_err   = err_q;
`else
  assign cfg.cfg_err   = 1'b0;
`endif

  assign s        = table_q[{a, b, c}];
  assign cfg_word = table_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with a commit scoreboard.
// Expected tables are queued at load time and popped on cfg_done.
module tb_lut_cfg_loader;
  logic       clk;
  logic       rst_n;
  logic       a, b, c;
  logic       s;
  logic [7:0] cfg_word;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [7:0] cur;
  logic [7:0] exp_q[$];

  lut_cfg_loader_if ifc ();

  lut_cfg_loader #(.INIT(8'hFF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (ifc.slave),
    .a        (a),
    .b        (b),
    .c        (c),
    .s        (s),
    .cfg_word (cfg_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued load.
  always @(negedge clk) begin
    if (rst_n && ifc.cfg_done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", 8'd1, 8'd0);
      else chk("sb_commit_word", cfg_word, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s_rand(input string tag);
    logic [2:0] sel;
    sel = 3'($urandom_range(0, 7));
    {a, b, c} = sel;
    #1;
    chk(tag, {7'd0, s}, {7'd0, cur[sel]});
  endtask

  // Junk bit rides along with start and must be discarded.
  task automatic pulse_start();
    ifc.cfg_start = 1'b1;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_din   = 1'b1;
    tick();
    ifc.cfg_start = 1'b0;
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic send_bit(input logic bv);
    int n;
    n = 0;
    ifc.cfg_din   = bv;
    ifc.cfg_valid = 1'b1;
    while (!ifc.cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 8'd0, 8'd1);
    tick();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] w, input logic bad_par,
                           input bit gap);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        tick();
        chk_s_rand("s_old_gap");
      end
      send_bit(w[i]);
      chk_s_rand("s_old_shift");
      chk("word_hold", cfg_word, cur);
    end
`ifdef LUT_CFG_PARITY_EN
    send_bit((^w) ^ bad_par);
`else
    if (bad_par) chk("bad_par_unused", 8'd1, 8'd0);
`endif
  endtask

  task automatic expect_commit(input logic [7:0] w);
    chk("pre_commit_word", cfg_word, cur);
    chk("pre_commit_done", {7'd0, ifc.cfg_done}, 8'd0);
    tick();
    chk("done_pulse", {7'd0, ifc.cfg_done}, 8'd1);
    chk("commit_word", cfg_word, w);
    cur = w;
    exp_done++;
    tick();
    chk("done_single", {7'd0, ifc.cfg_done}, 8'd0);
    chk("ready_idle", {7'd0, ifc.cfg_ready}, 8'd0);
  endtask

  task automatic sweep(input string tag, input int kind);
    logic [7:0] req;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      case (kind)
        1:       req = {7'd0, a ^ b ^ c};
        2:       req = {7'd0, (a & b) | (a & c) | (b & c)};
        default: req = {7'd0, cur[i]};
      endcase
      chk(tag, {7'd0, s}, req);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.cfg_start = 1'b0;
    ifc.cfg_din   = 1'b0;
    ifc.cfg_valid = 1'b0;
    {a, b, c} = 3'd0;
    cur = 8'hFF;
    #12;
    chk("rst_word", cfg_word, 8'hFF);
    chk("rst_ready", {7'd0, ifc.cfg_ready}, 8'd0);
    chk("rst_done", {7'd0, ifc.cfg_done}, 8'd0);
    chk("rst_err", {7'd0, ifc.cfg_err}, 8'd0);
    sweep("rst_s", 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {7'd0, ifc.cfg_ready}, 8'd0);

    // XOR3 table.
    exp_q.push_back(8'h96);
    load_word(8'h96, 1'b0, 1'b0);
    expect_commit(8'h96);
    sweep("xor3_s", 1);

    // Majority from INIT, valid toggling every cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cur = 8'hFF;
    chk("rst2_word", cfg_word, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'hE8);
    load_word(8'hE8, 1'b0, 1'b1);
    expect_commit(8'hE8);
    sweep("maj_s", 2);

`ifdef LUT_CFG_PARITY_EN
    // Bad parity is rejected and the table stays.
    load_word(8'h3C, 1'b1, 1'b0);
    chk("perr_pulse", {7'd0, ifc.cfg_err}, 8'd1);
    chk("perr_done", {7'd0, ifc.cfg_done}, 8'd0);
    tick();
    chk("perr_single", {7'd0, ifc.cfg_err}, 8'd0);
    chk("perr_word", cfg_word, 8'hE8);
    chk("perr_ready", {7'd0, ifc.cfg_ready}, 8'd0);
`endif

    // Abort after 5 ones, then a clean 8'h01.
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    exp_q.push_back(8'h01);
    load_word(8'h01, 1'b0, 1'b0);
    expect_commit(8'h01);
    sweep("abort_s", 0);

    // Start during COMMIT is ignored.
    exp_q.push_back(8'h5A);
    load_word(8'h5A, 1'b0, 1'b0);
    ifc.cfg_start = 1'b1;
    tick();
    ifc.cfg_start = 1'b0;
    chk("cstart_done", {7'd0, ifc.cfg_done}, 8'd1);
    chk("cstart_word", cfg_word, 8'h5A);
    chk("cstart_ready", {7'd0, ifc.cfg_ready}, 8'd0);
    cur = 8'h5A;
    exp_done++;
    tick();

    // Reset mid-load of 8'h0F.
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    cur = 8'hFF;
    chk("mid_rst_word", cfg_word, 8'hFF);
    chk("mid_rst_ready", {7'd0, ifc.cfg_ready}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.cfg_valid = 1'b1;
    tick();
    chk("post_rst_ready", {7'd0, ifc.cfg_ready}, 8'd0);
    tick();
    chk("post_rst_ready2", {7'd0, ifc.cfg_ready}, 8'd0);
    chk("post_rst_word", cfg_word, 8'hFF);
    ifc.cfg_valid = 1'b0;
    sweep("post_rst_s", 0);

    repeat (3) tick();
    chk("done_count", 8'(done_cnt), 8'(exp_done));
    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
